data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
Parametrised data memory for the ARM pipelined core. It is the successor to the fixed single-port 32-bit RAM on the core's ALUResult/WriteData bus. Adds:
- configurable width, depth and read latency;
- byte-lane writes;
- read-during-write mode selection;
- out-of-range/misalignment fault reporting;
- a post-reset zeroing sweep with a ready flag.

The core's memory stage connects here. The camera frame path reuses it with wider DATA_WIDTH.

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8, 8..128
ADDR_WIDTH, 32, byte-address width
DEPTH, 64, number of words; power of two, >=2
READ_LATENCY, 1, cycles from accepted read to read_valid; legal 1..3
RDW_MODE, 0, same-address read+write: 0 returns old data, 1 returns new (merged) data
BASE_ADDR, 0, byte address of word 0; must be word aligned

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
address  in  ADDR_WIDTH  byte address (ALUResult)
write_data  in  DATA_WIDTH  store data (WriteData)
write_enable  in  1  store request
byte_en  in  DATA_WIDTH/8  per-byte write mask; bit i covers bits 8i+7:8i
read_enable  in  1  load request
read_data  out  DATA_WIDTH  load data (ReadData); valid while read_valid=1
read_valid  out  1  one-cycle pulse per accepted read
fault  out  1  one-cycle pulse, same cycle as the access is presented
ready  out  1  1 when requests are accepted

Behaviour:
- Reset values (next edge with reset=1): read_data=0, read_valid=0, fault=0, ready=0, read pipeline flushed, sweep counter=0, FSM->INIT.
- FSM INIT:
  - writes 0 to word[cnt] each cycle, cnt 0..DEPTH-1;
  - all requests ignored, no fault;
  - after writing word DEPTH-1, go to READY (ready=1 from that next cycle);
  - INIT lasts exactly DEPTH cycles.
- FSM READY: stays until reset. Reset in any state, including mid-sweep, restarts INIT at cnt=0.
- Decode:
  - off = address - BASE_ADDR;
  - lane bits = off[log2(DATA_WIDTH/8)-1:0];
  - idx = off >> log2(DATA_WIDTH/8).
- Access is illegal if lane bits != 0, or address < BASE_ADDR, or idx >= DEPTH.
- Illegal access when ready=1 and (read_enable|write_enable):
  - fault=1 combinationally that cycle, registered copy not used;
  - write suppressed;
  - a read still produces read_valid after READ_LATENCY with read_data=0.
- Write: on edge with ready & write_enable & legal, bytes with byte_en[i]=1 updated; others unchanged. byte_en=0 performs no update and no fault.
- Read: accepted when ready & read_enable. Data sampled at the accept edge, then delayed through READ_LATENCY-1 further register stages, so read_valid and read_data appear READ_LATENCY cycles after the request cycle.
  - One read per cycle, fully pipelined, no back-pressure.
  - read_data holds its last value when read_valid=0.
- Simultaneous read+write, same idx:
  - RDW_MODE=0 returns pre-write word;
  - RDW_MODE=1 returns merged word (new bytes where byte_en=1).
- Different idx: independent.
- Address wrap: no wrap; idx>=DEPTH always faults.

Decomposition:
- Shared package mem_pkg:
  - FSM state enum {INIT, READY};
  - localparam helpers BYTES=DATA_WIDTH/8, LANE_BITS=$clog2(BYTES), IDX_BITS=$clog2(DEPTH);
  - a function merging bytes by mask.
- One sub-module, mem_rd_pipe: a parametrised delay line (READ_LATENCY-1 stages) carrying {valid, data} with synchronous reset.
- Storage array and FSM stay in data_mem_ctrl.

Test Plan:
- Reset then idle, DEPTH=64 -> ready=0 for 64 cycles, ready=1 on cycle 65; reading every idx returns 0.
- Write 0xDEADBEEF to addr 0x10 byte_en=4'b1111, then write 0x000000AA byte_en=4'b0001, read 0x10 with READ_LATENCY=2 -> read_valid 2 cycles after request, read_data=0xDEADBEAA.
- Same-cycle read+write addr 0x08 (old 0x11111111, new 0x22222222, full mask) -> RDW_MODE=0 returns 0x11111111; RDW_MODE=1 returns 0x22222222.
- Access addr 0x102 (misaligned) and 0x100 (idx 64, out of range) -> fault pulse each; memory unchanged; reads return 0 with read_valid.
- Back-to-back reads idx 0..7 at READ_LATENCY=3 -> eight consecutive read_valid pulses starting cycle 3, data in order.
- Assert reset at sweep cnt=30, release -> ready stays 0 for a full 64 cycles; a write issued during INIT is not stored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the parametrised data memory.
// Helpers are sized for the widest supported word (128 bits / 16 byte lanes).
package mem_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int MAX_DATA_WIDTH = 128;
  localparam int MAX_BYTES      = MAX_DATA_WIDTH / 8;

  // Take each byte from new_w where mask is set, otherwise keep old_w.
  function automatic logic [MAX_DATA_WIDTH-1:0] merge_bytes(
    input logic [MAX_DATA_WIDTH-1:0] old_w,
    input logic [MAX_DATA_WIDTH-1:0] new_w,
    input logic [MAX_BYTES-1:0]      mask
  );
    logic [MAX_DATA_WIDTH-1:0] m;
    m = old_w;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (mask[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return delay line of STAGES register stages carrying {valid, data}.
// Data registers only load on valid, so the output holds the last returned word.
module mem_rd_pipe #(
  parameter int STAGES = 0,
  parameter int WIDTH  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  if (STAGES == 0) begin : g_bypass
    logic unused_pipe;
    assign unused_pipe = clk ^ reset;
    assign valid_o     = valid_i;
    assign data_o      = data_i;
  end else begin : g_stages
    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= '0;
        for (int s = 0; s < STAGES; s++) data_q[s] <= '0;
      end else begin
        valid_q[0] <= valid_i;
        if (valid_i) data_q[0] <= data_i;
        for (int s = 1; s < STAGES; s++) begin
          valid_q[s] <= valid_q[s-1];
          if (valid_q[s-1]) data_q[s] <= data_q[s-1];
        end
      end
    end

    assign valid_o = valid_q[STAGES-1];
    assign data_o  = data_q[STAGES-1];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Parametrised data memory for the core's memory stage: byte-lane writes,
// selectable read-during-write, fault pulse, and a zeroing sweep after reset.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DEPTH        = 64,
  parameter int                    READ_LATENCY = 1,
  parameter int                    RDW_MODE     = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic                    write_enable,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic                    read_enable,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_valid,
  output logic                    fault,
  output logic                    ready
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(BYTES);
  localparam int IDX_BITS  = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
  localparam logic [IDX_BITS-1:0]   LAST_IDX  = IDX_BITS'(DEPTH - 1);

  state_e                state_q;
  logic [IDX_BITS-1:0]   cnt_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Handshake: a request (read_enable or write_enable) is taken on the rising
  // edge only while ready=1; there is no back-pressure once ready is high, and
  // every taken read returns exactly one read_valid pulse READ_LATENCY later.

  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] idx_full;
  logic [IDX_BITS-1:0]   idx;
  logic                  below_base;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  legal;
  logic                  wr_go;
  logic                  rd_go;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] rd_data_d;

  assign off          = address - BASE_ADDR;
  assign idx_full     = off >> LANE_BITS;
  assign idx          = idx_full[IDX_BITS-1:0];
  assign below_base   = address < BASE_ADDR;
  assign misaligned   = (off & LANE_MASK) != '0;
  assign out_of_range = idx_full >= DEPTH_A;
  assign legal        = !(below_base || misaligned || out_of_range);

  assign fault = ready_q && (read_enable || write_enable) && !legal;
  assign wr_go = ready_q && write_enable && legal && !reset;
  assign rd_go = ready_q && read_enable;

  assign old_word    = mem_q[idx];
  assign merged_word = DATA_WIDTH'(merge_bytes(MAX_DATA_WIDTH'(old_word),
                                               MAX_DATA_WIDTH'(write_data),
                                               MAX_BYTES'(byte_en)));

  // Illegal reads still return a pulse, carrying zero.
  always_comb begin
    rd_data_d = old_word;
    if (!legal) begin
      rd_data_d = '0;
    end else if (RDW_MODE == 1 && wr_go) begin
      rd_data_d = merged_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= INIT;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == INIT) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_go) begin
        mem_q[idx] <= merged_word;
      end
    end
  end

  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_go;
      if (rd_go) rd_data_q <= rd_data_d;
    end
  end

  mem_rd_pipe #(
    .STAGES (READ_LATENCY - 1),
    .WIDTH  (DATA_WIDTH)
  ) u_rd_pipe (
    .clk     (clk),
    .reset   (reset),
    .valid_i (rd_valid_q),
    .data_i  (rd_data_q),
    .valid_o (read_valid),
    .data_o  (read_data)
  );

  assign ready = ready_q;

endmodule
